md_audio_mixer: RTL and testbench
=================================

Name: md_audio_mixer

Overview:
- Parametrised N-channel stereo audio mixer for the console top level.
- Takes strobed sample sources: FM MOL/MOR per-slot outputs, the PSG level, and future add-on channels.
- Applies per-channel gain and L/R pan, then accumulates with a time-multiplexed single MAC.
- Emits saturated stereo samples at a fixed frame rate derived from MCLK.

Parameters:
- NCH, 4, number of input channels (2..16)
- IN_W, 16, signed input sample width
- OUT_W, 16, signed output width; must be >= IN_W
- DIV, 144, MCLK_e-qualified cycles per output frame; must be >= NCH+3

Ports:
- MCLK  in  1  master clock; all flops clock on rising edge
- RESET  in  1  synchronous active-high reset
- MCLK_e  in  1  clock enable; state advances only when high (RESET acts regardless)
- ch_data  in  NCH*IN_W  per-channel signed samples, channel k at bits [k*IN_W +: IN_W]
- ch_strobe  in  NCH  per-channel sample-ready pulse, one enabled cycle
- ch_gain  in  NCH*8  unsigned gain per channel; 0x80 = unity, 0xFF ~ 1.99x
- ch_pan  in  NCH*2  per channel: bit1 = left enable, bit0 = right enable
- out_l  out  OUT_W  mixed left sample
- out_r  out  OUT_W  mixed right sample
- out_valid  out  1  one enabled-cycle pulse when out_l/out_r update
- clip  out  1  sticky; set when any frame saturated, cleared by RESET only

Behaviour:
- Reset: all hold/snapshot registers 0; accumulators 0; divider 0; FSM IDLE; out_l = out_r = 0; out_valid = 0; clip = 0.
- Hold stage: on ch_strobe[k], hold[k] <= ch_data[k]. Without a strobe, hold keeps its value (sample-and-hold).
- Frame tick: divider counts 0..DIV-1 on enabled cycles; tick when count == DIV-1, then wrap to 0.
- On tick:
  - snapshot[k] <= hold[k] for all k.
  - If ch_strobe[k] is active in the same cycle, snapshot takes the new ch_data[k] (bypass).
  - Gain and pan are also snapshotted on the tick.
- FSM states IDLE -> ACC -> SAT -> IDLE:
  - IDLE: on tick, clear acc_l/acc_r; idx <= 0; go to ACC.
  - ACC: one channel per enabled cycle.
    - p = sext(snapshot[idx]) * {1'b0, gain[idx]} >>> 7 (arithmetic shift, truncate toward -inf).
    - acc_l += pan[idx][1] ? p : 0; acc_r += pan[idx][0] ? p : 0.
    - After idx == NCH-1, go to SAT.
  - SAT: clamp each acc to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and register into out_l/out_r. Set clip if either side clamped. out_valid = 1 for this one cycle. Return to IDLE.
- Widths:
  - Product is IN_W+9 bits signed.
  - ACC_W = IN_W + 2 + clog2(NCH); no internal overflow is possible.
  - Sign-extend to OUT_W before the clamp when OUT_W > ACC_W.
- Latency: tick to out_valid = NCH+2 enabled cycles.
- Strobes arriving during ACC/SAT update hold only. They never alter the frame in progress and are used at the next tick.
- A tick cannot arrive outside IDLE, because DIV >= NCH+3. Any DIV below this is an elaboration error ($error in generate).
- MCLK_e low: everything freezes, including the divider and FSM; out_valid stays high only if it was high on the last enabled cycle and is consumed as a pulse on enabled cycles only.
- RESET mid-frame: abort immediately; outputs return to reset values on the next edge.
- Pan 2'b00 channel contributes 0; gain 0 contributes 0.

Optional Feature:
- Macro: MD_AUDIO_MIXER_DCBLOCK_EN.
- With it defined: each side passes through a first-order DC blocker between the clamp and the output register.
  - y[n] = x[n] - x[n-1] + y[n-1] - (y[n-1] >>> 8), computed in OUT_W+2 bits, then clamped again.
  - This adds 1 enabled cycle of latency (NCH+3 total).
  - The filter state resets to 0.
- Without it: the clamp feeds out_l/out_r directly, with latency NCH+2.

Decomposition:
- Package md_audio_pkg holds:
  - function sat_clamp(value, width)
  - constants GAIN_UNITY = 8'h80, GAIN_SHIFT = 7, DCB_SHIFT = 8
  - typedef mix_state_t {IDLE, ACC, SAT}
- Sub-module md_audio_mac: one gain-multiply/pan/accumulate lane, instantiated twice (L, R) sharing the product.

Test Plan:
- NCH=4, DIV=16. ch0 = 16'sd1000 with gain 0x80 pan 11, others pan 00 -> every frame out_l = out_r = 1000, out_valid 6 cycles after the tick, period 16.
- ch0 = 30000, ch1 = 30000, both unity, pan 10 -> out_l = 32767, out_r = 0, clip = 1 and stays 1 after the inputs go to 0.
- ch0 = -32768 with gain 0xFF pan 11 -> out = -32768 (clamped); ch0 = -3 with gain 0x40 -> out = -2 (floor of -1.5).
- Strobe ch2 with 500 during ACC after a tick-time hold of 100 (unity, pan 11, others pan 00) -> current frame uses 100; next frame uses 500.
- Strobe coincident with the tick carrying 777 (unity, pan 11, others pan 00) -> this frame outputs 777. Assert RESET at ACC idx 2 -> no out_valid that frame; outputs 0; the next valid output arrives after a full DIV.
- With DCBLOCK_EN: constant ch0 = 1000 unity -> first output 1000, then decays monotonically toward 0; latency is NCH+3.

Source files
------------

// File: rtl/md_audio_pkg.sv
// Shared types, constants and saturation helper for the stereo audio mixer.
// Latency: none (package only).
// Backpressure: none (package only).
package md_audio_pkg;

  localparam logic [7:0] GAIN_UNITY = 8'h80;
  localparam int         GAIN_SHIFT = 7;
  localparam int         DCB_SHIFT  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    SAT  = 2'd2
  } mix_state_t;

  // Clamp a wide signed value into the signed range of 'width' bits.
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] value,
                                                   input int                 width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) begin
      sat_clamp = hi;
    end else if (value < lo) begin
      sat_clamp = lo;
    end else begin
      sat_clamp = value;
    end
  endfunction

endpackage

// File: rtl/md_audio_mac.sv
// One accumulate lane of the mixer: adds the shared gained product when its pan bit is set.
// Latency: 1 enabled cycle per accumulate.
// Backpressure: none; advances only on enabled cycles.
module md_audio_mac #(
  parameter int ACC_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             add,
  input  logic             pan,
  input  logic [ACC_W-1:0] prod,
  output logic [ACC_W-1:0] acc
);

  // Accumulator: clear at frame start, add product for each panned channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      if (clr) begin
        acc <= '0;
      end else if (add && pan) begin
        acc <= acc + prod;
      end
    end
  end

endmodule

// File: rtl/md_audio_mixer.sv
// N-channel stereo mixer: sample-and-hold, per-frame snapshot, single shared MAC, saturating output.
// Latency: tick to out_valid NCH+2 enabled cycles (NCH+3 with MD_AUDIO_MIXER_DCBLOCK_EN defined).
// Backpressure: none; MCLK_e low freezes all state, out_valid is a pulse on enabled cycles.
module md_audio_mixer
  import md_audio_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int IN_W  = 16,
  parameter int OUT_W = 16,
  parameter int DIV   = 144
) (
  input  logic               MCLK,
  input  logic               RESET,
  input  logic               MCLK_e,
  input  logic [NCH*IN_W-1:0] ch_data,
  input  logic [NCH-1:0]      ch_strobe,
  input  logic [NCH*8-1:0]    ch_gain,
  input  logic [NCH*2-1:0]    ch_pan,
  output logic [OUT_W-1:0]    out_l,
  output logic [OUT_W-1:0]    out_r,
  output logic                out_valid,
  output logic                clip
);

  localparam int IDX_W = $clog2(NCH);
  localparam int CNT_W = $clog2(DIV);
  localparam int ACC_W = IN_W + 2 + $clog2(NCH);

  generate
    if (DIV < NCH + 3) begin : g_div_chk
      $error("md_audio_mixer: DIV must be >= NCH+3");
    end
    if (OUT_W < IN_W) begin : g_out_chk
      $error("md_audio_mixer: OUT_W must be >= IN_W");
    end
  endgenerate

  logic [IN_W-1:0]  hold   [NCH];
  logic [IN_W-1:0]  snap   [NCH];
  logic [7:0]       gain_s [NCH];
  logic [1:0]       pan_s  [NCH];

  logic [CNT_W-1:0] cnt;
  logic             tick;

  mix_state_t       state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             acc_clr, acc_add;

  logic signed [IN_W-1:0] cur_smp;
  logic [7:0]             cur_gain;
  logic [1:0]             cur_pan;
  logic signed [IN_W+8:0] prod_full;
  logic signed [IN_W+8:0] prod_sh;
  logic [ACC_W-1:0]       prod_acc;
  logic [ACC_W-1:0]       acc_l, acc_r;

  logic signed [63:0] wide_l, wide_r, clamp_l, clamp_r;
  logic               clip_l, clip_r;

  assign tick = MCLK_e && (cnt == CNT_W'(DIV - 1));

  // Frame divider: counts enabled cycles, wraps after DIV-1.
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      cnt <= '0;
    end else if (MCLK_e) begin
      cnt <= (cnt == CNT_W'(DIV - 1)) ? '0 : cnt + CNT_W'(1);
    end
  end

  // Sample-and-hold of each channel on its strobe.
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      for (int k = 0; k < NCH; k++) hold[k] <= '0;
    end else if (MCLK_e) begin
      for (int k = 0; k < NCH; k++) begin
        if (ch_strobe[k]) hold[k] <= ch_data[k*IN_W +: IN_W];
      end
    end
  end

  // Frame snapshot; a strobe coincident with the tick bypasses the hold register.
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      for (int k = 0; k < NCH; k++) begin
        snap[k]   <= '0;
        gain_s[k] <= '0;
        pan_s[k]  <= '0;
      end
    end else if (tick) begin
      for (int k = 0; k < NCH; k++) begin
        snap[k]   <= ch_strobe[k] ? ch_data[k*IN_W +: IN_W] : hold[k];
        gain_s[k] <= ch_gain[k*8 +: 8];
        pan_s[k]  <= ch_pan[k*2 +: 2];
      end
    end
  end

  // Sequencer state register.
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      state <= IDLE;
      idx   <= '0;
    end else if (MCLK_e) begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Sequencer next-state: wait for tick, walk channels, then saturate.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    acc_clr   = 1'b0;
    acc_add   = 1'b0;
    case (state)
      IDLE: begin
        if (tick) begin
          acc_clr   = 1'b1;
          idx_nxt   = '0;
          state_nxt = ACC;
        end
      end
      ACC: begin
        acc_add = 1'b1;
        if (idx == IDX_W'(NCH - 1)) begin
          state_nxt = SAT;
        end else begin
          idx_nxt = idx + IDX_W'(1);
        end
      end
      SAT: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Shared gain product for the channel being accumulated (floor division by 128).
  always_comb begin
    cur_smp   = $signed(snap[idx]);
    cur_gain  = gain_s[idx];
    cur_pan   = pan_s[idx];
    prod_full = (IN_W + 9)'(cur_smp) * $signed({{IN_W{1'b0}}, 1'b0, cur_gain});
    prod_sh   = prod_full >>> GAIN_SHIFT;
    prod_acc  = ACC_W'(prod_sh);
  end

  md_audio_mac #(.ACC_W(ACC_W)) u_mac_l (
    .clk  (MCLK),
    .rst  (RESET),
    .en   (MCLK_e),
    .clr  (acc_clr),
    .add  (acc_add),
    .pan  (cur_pan[1]),
    .prod (prod_acc),
    .acc  (acc_l)
  );

  md_audio_mac #(.ACC_W(ACC_W)) u_mac_r (
    .clk  (MCLK),
    .rst  (RESET),
    .en   (MCLK_e),
    .clr  (acc_clr),
    .add  (acc_add),
    .pan  (cur_pan[0]),
    .prod (prod_acc),
    .acc  (acc_r)
  );

  // Saturate both accumulators to the output range.
  always_comb begin
    wide_l  = 64'($signed(acc_l));
    wide_r  = 64'($signed(acc_r));
    clamp_l = sat_clamp(wide_l, OUT_W);
    clamp_r = sat_clamp(wide_r, OUT_W);
    clip_l  = (clamp_l != wide_l);
    clip_r  = (clamp_r != wide_r);
  end

`ifdef MD_AUDIO_MIXER_DCBLOCK_EN
  logic [OUT_W-1:0]       sat_l, sat_r;
  logic                   sat_vld;
  logic [OUT_W-1:0]       xp_l, xp_r;
  logic signed [OUT_W+1:0] dcb_l, dcb_r;
  logic signed [63:0]     dcbw_l, dcbw_r, dcbc_l, dcbc_r;
  logic                   dclip_l, dclip_r;

  // DC blocker: y = x - x_prev + y_prev - y_prev/256, previous y is the output register.
  always_comb begin
    dcb_l   = (OUT_W + 2)'($signed(sat_l)) - (OUT_W + 2)'($signed(xp_l))
            + (OUT_W + 2)'($signed(out_l)) - (OUT_W + 2)'($signed(out_l) >>> DCB_SHIFT);
    dcb_r   = (OUT_W + 2)'($signed(sat_r)) - (OUT_W + 2)'($signed(xp_r))
            + (OUT_W + 2)'($signed(out_r)) - (OUT_W + 2)'($signed(out_r) >>> DCB_SHIFT);
    dcbw_l  = 64'(dcb_l);
    dcbw_r  = 64'(dcb_r);
    dcbc_l  = sat_clamp(dcbw_l, OUT_W);
    dcbc_r  = sat_clamp(dcbw_r, OUT_W);
    dclip_l = (dcbc_l != dcbw_l);
    dclip_r = (dcbc_r != dcbw_r);
  end

  // Clamp stage register, then filter stage into the outputs one enabled cycle later.
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      sat_l     <= '0;
      sat_r     <= '0;
      sat_vld   <= 1'b0;
      xp_l      <= '0;
      xp_r      <= '0;
      out_l     <= '0;
      out_r     <= '0;
      out_valid <= 1'b0;
      clip      <= 1'b0;
    end else if (MCLK_e) begin
      sat_vld   <= (state == SAT);
      out_valid <= sat_vld;
      if (state == SAT) begin
        sat_l <= clamp_l[OUT_W-1:0];
        sat_r <= clamp_r[OUT_W-1:0];
        if (clip_l || clip_r) clip <= 1'b1;
      end
      if (sat_vld) begin
        out_l <= dcbc_l[OUT_W-1:0];
        out_r <= dcbc_r[OUT_W-1:0];
        xp_l  <= sat_l;
        xp_r  <= sat_r;
        if (dclip_l || dclip_r) clip <= 1'b1;
      end
    end
  end
`else
  // Clamped accumulators go straight to the output registers.
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      out_l     <= '0;
      out_r     <= '0;
      out_valid <= 1'b0;
      clip      <= 1'b0;
    end else if (MCLK_e) begin
      out_valid <= (state == SAT);
      if (state == SAT) begin
        out_l <= clamp_l[OUT_W-1:0];
        out_r <= clamp_r[OUT_W-1:0];
        if (clip_l || clip_r) clip <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_md_audio_mixer.sv
// Directed bench for md_audio_mixer with NCH=4, DIV=16, 16-bit in/out.
// Expected values are hand-computed; frame timing is measured relative to out_valid.
// Covers MD_AUDIO_MIXER_DCBLOCK_EN when the macro is defined for the build.
module tb_md_audio_mixer;
  import md_audio_pkg::*;

  localparam int NCH   = 4;
  localparam int IN_W  = 16;
  localparam int OUT_W = 16;
  localparam int DIV   = 16;

  logic                MCLK = 1'b0;
  logic                RESET;
  logic                MCLK_e;
  logic [NCH*IN_W-1:0] ch_data;
  logic [NCH-1:0]      ch_strobe;
  logic [NCH*8-1:0]    ch_gain;
  logic [NCH*2-1:0]    ch_pan;
  logic [OUT_W-1:0]    out_l;
  logic [OUT_W-1:0]    out_r;
  logic                out_valid;
  logic                clip;

  int n_checks = 0;
  int n_errors = 0;

  md_audio_mixer #(.NCH(NCH), .IN_W(IN_W), .OUT_W(OUT_W), .DIV(DIV)) dut (
    .MCLK      (MCLK),
    .RESET     (RESET),
    .MCLK_e    (MCLK_e),
    .ch_data   (ch_data),
    .ch_strobe (ch_strobe),
    .ch_gain   (ch_gain),
    .ch_pan    (ch_pan),
    .out_l     (out_l),
    .out_r     (out_r),
    .out_valid (out_valid),
    .clip      (clip)
  );

  always #5 MCLK = ~MCLK;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge MCLK);
    #1;
  endtask

  task automatic set_ch(input int k, input int d, input int g, input int p);
    ch_data[k*IN_W +: IN_W] = IN_W'(d);
    ch_gain[k*8 +: 8]       = 8'(g);
    ch_pan[k*2 +: 2]        = 2'(p);
  endtask

  task automatic strobe(input logic [NCH-1:0] mask);
    ch_strobe = mask;
    step();
    ch_strobe = '0;
  endtask

  // Wait for out_valid (bounded), then check edge count and both outputs.
  task automatic expect_frame(input string tag, input int lat, input int l, input int r);
    int  n;
    bit  seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      step();
      n++;
      if (out_valid) seen = 1'b1;
    end
    if (!seen) check({tag, "_timeout"}, 0, 1);
    check({tag, "_lat"}, n, lat);
    check({tag, "_l"}, $signed(out_l), l);
    check({tag, "_r"}, $signed(out_r), r);
  endtask

  initial begin
    RESET     = 1'b1;
    MCLK_e    = 1'b1;
    ch_data   = '0;
    ch_strobe = '0;
    ch_gain   = {NCH{GAIN_UNITY}};
    ch_pan    = '0;
    repeat (3) step();
    check("rst_l", $signed(out_l), 0);
    check("rst_r", $signed(out_r), 0);
    check("rst_vld", out_valid, 0);
    check("rst_clip", clip, 0);

    // First tick is the 16th enabled cycle after release; strobe uses edge 1.
    set_ch(0, 1000, 8'h80, 2'b11);
    RESET = 1'b0;
    strobe(4'b0001);
`ifdef MD_AUDIO_MIXER_DCBLOCK_EN
    expect_frame("dc0", 21, 1000, 1000);
    expect_frame("dc1", 16, 997, 997);
    expect_frame("dc2", 16, 994, 994);
    expect_frame("dc3", 16, 991, 991);
`else
    expect_frame("f0", 20, 1000, 1000);
    step();
    check("pulse", out_valid, 0);
    expect_frame("f1", 15, 1000, 1000);

    // Two full-scale channels left only: left saturates, clip sticks.
    set_ch(0, 30000, 8'h80, 2'b10);
    set_ch(1, 30000, 8'h80, 2'b10);
    strobe(4'b0011);
    expect_frame("sat", 15, 32767, 0);
    check("clip_set", clip, 1);
    set_ch(0, 0, 8'h80, 2'b10);
    set_ch(1, 0, 8'h80, 2'b00);
    strobe(4'b0011);
    expect_frame("zero", 15, 0, 0);
    check("clip_sticky", clip, 1);

    // Negative full scale at max gain clamps; -3*0x40/128 floors to -2.
    set_ch(0, -32768, 8'hFF, 2'b11);
    strobe(4'b0001);
    expect_frame("neg", 15, -32768, -32768);
    set_ch(0, -3, 8'h40, 2'b11);
    strobe(4'b0001);
    expect_frame("floor", 15, -2, -2);
    set_ch(0, 1000, 8'h00, 2'b11);
    strobe(4'b0001);
    expect_frame("gain0", 15, 0, 0);

    // Mixed panning: 200*255/128 floors to 398.
    set_ch(0, 1000, 8'h80, 2'b11);
    set_ch(1, -300, 8'h80, 2'b01);
    set_ch(2, 200, 8'hFF, 2'b10);
    set_ch(3, 50, 8'h80, 2'b00);
    strobe(4'b1111);
    expect_frame("mix", 15, 1398, 700);

    // Strobe during ACC only updates hold for the next frame.
    set_ch(0, 0, 8'h80, 2'b00);
    set_ch(1, 0, 8'h80, 2'b00);
    set_ch(2, 100, 8'h80, 2'b11);
    set_ch(3, 0, 8'h80, 2'b00);
    strobe(4'b0100);
    expect_frame("h100", 15, 100, 100);
    repeat (12) step();
    set_ch(2, 500, 8'h80, 2'b11);
    strobe(4'b0100);
    expect_frame("inacc", 3, 100, 100);
    expect_frame("next", 16, 500, 500);

    // Strobe coincident with the tick is bypassed into this frame.
    repeat (10) step();
    set_ch(2, 777, 8'h80, 2'b11);
    strobe(4'b0100);
    expect_frame("bypass", 5, 777, 777);

    // Reset at ACC idx 2 aborts the frame and clears everything.
    repeat (13) step();
    RESET = 1'b1;
    step();
    check("mid_l", $signed(out_l), 0);
    check("mid_r", $signed(out_r), 0);
    check("mid_vld", out_valid, 0);
    check("mid_clip", clip, 0);
    RESET = 1'b0;
    strobe(4'b0100);
    expect_frame("post_rst", 20, 777, 777);

    // Clock enable low freezes out_valid and outputs.
    MCLK_e = 1'b0;
    repeat (3) step();
    check("frz_vld", out_valid, 1);
    check("frz_l", $signed(out_l), 777);
    MCLK_e = 1'b1;
    step();
    check("frz_pulse", out_valid, 0);
    expect_frame("frz_next", 15, 777, 777);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
